bcd_clock_counter: RTL and testbench
====================================

BCD_CLOCK_COUNTER -- requirements
Module: bcd_clock_counter

Interface
REQ-001 Parameters (name, default, meaning): TICK_DIV, 50000000, clk cycles per second tick; SCAN_DIV, 50000, clk cycles per display digit slot.
REQ-002 clk  input  1  system clock, all logic rising-edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 run  input  1  1 = timekeeping advances, 0 = seconds frozen.
REQ-005 inc_min  input  1  single-cycle pulse, synchronous and debounced upstream; advances minutes.
REQ-006 inc_hr  input  1  single-cycle pulse, synchronous and debounced upstream; advances hours.
REQ-007 bcd  output  4  registered BCD digit for the downstream 7-segment decoder.
REQ-008 dig  output  6  registered one-hot active-high digit select; bit0 = seconds ones, bit5 = hours tens.
REQ-009 sec_tick  output  1  registered one-cycle pulse on each second advance.
REQ-010 pm  output  1  registered PM flag.

Function
REQ-011 Tick counter counts 0..TICK_DIV-1 while run=1, holds while run=0, wraps to 0 at TICK_DIV-1; sec_tick=1 in the cycle after the wrap.
REQ-012 Time is held as six BCD digits: seconds ones 0-9 and tens 0-5; minutes ones 0-9 and tens 0-5; hours per REQ-024/REQ-025.
REQ-013 On sec_tick: seconds +1; 59->00 carries +1 to minutes; minutes 59->00 carries +1 to hours.
REQ-014 inc_min=1: minutes +1 on the next edge, 59->00 with no carry to hours; seconds unaffected.
REQ-015 inc_hr=1: hours +1 on the next edge, wrapping per the active hour mode; minutes and seconds unaffected.
REQ-016 inc_min and a seconds carry into minutes in the same cycle: minutes advance by exactly 1; the carry is dropped.
REQ-017 inc_hr and a minutes carry into hours in the same cycle: hours advance by exactly 1.
REQ-018 inc_min and inc_hr together: both apply independently.
REQ-019 Digits never hold a non-BCD value or an out-of-range value; at every increment, out-of-range values are never produced.
REQ-020 Scan counter counts 0..SCAN_DIV-1 continuously, independent of run; at each wrap the digit index advances 0->1->...->5->0.
REQ-021 bcd and dig update together, one cycle after the index changes; dig always has exactly one bit set.
REQ-022 Hours tens digit is displayed as-is; leading zero is not blanked.
REQ-023 Time updates are visible on bcd no later than the next visit to that digit slot.

Configuration
REQ-024 With macro HOUR12_EN defined: hours run 12,01,02..11,12; pm toggles on each 11->12 transition (by carry or inc_hr); reset hours = 12, pm = 0.
REQ-025 Without HOUR12_EN: hours run 00..23, 23->00; pm is tied to 0; reset hours = 00.

Reset
REQ-026 rst_n=0 asynchronously clears the tick counter, scan counter, digit index 0, all time digits (hours per REQ-024/REQ-025), sec_tick=0, bcd=0, dig=6'b000001, pm=0.
REQ-027 Reset asserted mid-count discards partial tick and scan counts; after release, the first sec_tick occurs TICK_DIV cycles later.
REQ-028 Reset release is not required to be synchronous; the implementation synchronises internally, so the first counting edge is at most 2 cycles after release.

Verification
REQ-029 TICK_DIV=4, run=1 for 240 cycles from reset -> sec_tick every 4 cycles; time = 00:01:00.
REQ-030 Preload 23:59:59 via inc_hr/inc_min and ticks, then one sec_tick -> 00:00:00 without HOUR12_EN; with HOUR12_EN, 11:59:59 PM -> 12:00:00 and pm=0.
REQ-031 Minutes at 59, pulse inc_min -> minutes=00, hours unchanged, seconds unchanged.
REQ-032 Time 00:00:59, inc_min in the cycle the seconds carry occurs -> time 00:01:00, not 00:02:00.
REQ-033 SCAN_DIV=2, time 12:34:56 -> dig cycles 000001..100000 every 2 cycles; bcd = 6,5,4,3,2,1 in order.
REQ-034 rst_n pulsed low mid-count with run=0 -> all outputs at reset values immediately, no clock edge required; time frozen after release.

Source files
------------

// File: rtl/bcd_clock_counter.sv
// HH:MM:SS BCD clock with a multiplexed 6-digit scan output; 24h by default, 12h+PM with HOUR12_EN.
// Latency: time advances the edge after sec_tick rises; bcd/dig follow the digit index by one cycle.
// Backpressure: none; inc_min/inc_hr are single-cycle pulses accepted every cycle.
module bcd_clock_counter #(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       inc_min,
    input  logic       inc_hr,
    output logic [3:0] bcd,
    output logic [5:0] dig,
    output logic       sec_tick,
    output logic       pm
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
`ifdef HOUR12_EN
    localparam logic [3:0] RST_HT = 4'd1;
    localparam logic [3:0] RST_HO = 4'd2;
`else
    localparam logic [3:0] RST_HT = 4'd0;
    localparam logic [3:0] RST_HO = 4'd0;
`endif

    logic [1:0]    rst_sync;
    logic          ena;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] scan_cnt;
    logic [2:0]    idx;
    logic [3:0]    s_o, s_t, m_o, m_t, h_o, h_t;
    logic [3:0]    cur;
    logic          sec_carry, min_adv, hr_adv;

    // Assertion is asynchronous; release is synchronised and gates all counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign ena = rst_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            if (ena && run) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    sec_tick <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

    // A manual minute step absorbs a coincident seconds carry, and with it any hour carry.
    assign sec_carry = sec_tick && (s_o >= 4'd9) && (s_t >= 4'd5);
    assign min_adv   = inc_min || sec_carry;
    assign hr_adv    = inc_hr || (sec_carry && !inc_min && (m_o >= 4'd9) && (m_t >= 4'd5));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_o <= 4'd0;
            s_t <= 4'd0;
            m_o <= 4'd0;
            m_t <= 4'd0;
            h_o <= RST_HO;
            h_t <= RST_HT;
        end else if (ena) begin
            if (sec_tick) begin
                if (s_o >= 4'd9) begin
                    s_o <= 4'd0;
                    s_t <= (s_t >= 4'd5) ? 4'd0 : s_t + 4'd1;
                end else begin
                    s_o <= s_o + 4'd1;
                end
            end
            if (min_adv) begin
                if (m_o >= 4'd9) begin
                    m_o <= 4'd0;
                    m_t <= (m_t >= 4'd5) ? 4'd0 : m_t + 4'd1;
                end else begin
                    m_o <= m_o + 4'd1;
                end
            end
            if (hr_adv) begin
`ifdef HOUR12_EN
                if (h_t == 4'd1 && h_o == 4'd1) begin
                    h_o <= 4'd2;
                end else if (h_t >= 4'd1 && h_o >= 4'd2) begin
                    h_t <= 4'd0;
                    h_o <= 4'd1;
                end else if (h_o >= 4'd9) begin
                    h_t <= 4'd1;
                    h_o <= 4'd0;
                end else begin
                    h_o <= h_o + 4'd1;
                end
`else
                if (h_t >= 4'd2 && h_o >= 4'd3) begin
                    h_t <= 4'd0;
                    h_o <= 4'd0;
                end else if (h_o >= 4'd9) begin
                    h_t <= (h_t >= 4'd2) ? 4'd0 : h_t + 4'd1;
                    h_o <= 4'd0;
                end else begin
                    h_o <= h_o + 4'd1;
                end
`endif
            end
        end
    end

`ifdef HOUR12_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pm <= 1'b0;
        else if (ena && hr_adv && h_t == 4'd1 && h_o == 4'd1)
            pm <= ~pm;
    end
`else
    assign pm = 1'b0;
`endif

    // Scan keeps running while time is frozen so the display stays lit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= 3'd0;
        end else if (ena) begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        cur = 4'd0;
        case (idx)
            3'd0:    cur = s_o;
            3'd1:    cur = s_t;
            3'd2:    cur = m_o;
            3'd3:    cur = m_t;
            3'd4:    cur = h_o;
            3'd5:    cur = h_t;
            default: cur = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd <= 4'd0;
            dig <= 6'b000001;
        end else begin
            bcd <= cur;
            dig <= 6'b000001 << idx;
        end
    end
endmodule

// File: tb/tb_bcd_clock_counter.sv
// Directed bench for bcd_clock_counter with TICK_DIV=4, SCAN_DIV=2; follows HOUR12_EN if defined.
module tb_bcd_clock_counter;
    localparam int TICK = 4;
`ifdef HOUR12_EN
    localparam bit H12 = 1'b1;
`else
    localparam bit H12 = 1'b0;
`endif

    logic       clk, rst_n, run, inc_min, inc_hr;
    logic [3:0] bcd;
    logic [5:0] dig;
    logic       sec_tick, pm;

    int pass_cnt = 0;
    int total_cnt = 0;

    bcd_clock_counter #(.TICK_DIV(TICK), .SCAN_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .inc_min(inc_min), .inc_hr(inc_hr),
        .bcd(bcd), .dig(dig), .sec_tick(sec_tick), .pm(pm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          hr_n;
        int          min_n;
        logic [23:0] exp24;
        logic        pm24;
        logic [23:0] exp12;
        logic        pm12;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h, required %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_min(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); inc_min = 1'b1;
            @(negedge clk); inc_min = 1'b0;
        end
    endtask

    task automatic pulse_hr(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); inc_hr = 1'b1;
            @(negedge clk); inc_hr = 1'b0;
        end
    endtask

    // Returns number of cycles until sec_tick is seen high; 99 on timeout.
    task automatic wait_tick(output int cyc);
        cyc = 99;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (sec_tick) begin
                cyc = c;
                break;
            end
        end
    endtask

    // Leaves run=0 in the cycle sec_tick is high, so exactly n seconds are applied.
    task automatic run_ticks(input int n, output int bad);
        int c;
        bad = 0;
        run = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_tick(c);
            if (c != TICK) bad++;
        end
        run = 1'b0;
    endtask

    task automatic read_time(output logic [23:0] t, output logic ok);
        logic [3:0] d [6];
        logic [5:0] seen;
        ok = 1'b1; seen = '0;
        for (int i = 0; i < 6; i++) d[i] = 4'd0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (!$onehot(dig)) ok = 1'b0;
            else for (int j = 0; j < 6; j++) if (dig[j]) begin d[j] = bcd; seen[j] = 1'b1; end
        end
        if (seen != 6'h3f) ok = 1'b0;
        t = {d[5], d[4], d[3], d[2], d[1], d[0]};
    endtask

    vec_t        vt [11];
    logic [23:0] t;
    logic        ok;
    int          bad, c, hits;
    logic [5:0]  prev;
    logic [3:0]  exp_d [6];

    initial begin
        vt[0]  = '{0,  0,  24'h000000, 1'b0, 24'h120000, 1'b0};
        vt[1]  = '{1,  0,  24'h010000, 1'b0, 24'h010000, 1'b0};
        vt[2]  = '{0,  9,  24'h010900, 1'b0, 24'h010900, 1'b0};
        vt[3]  = '{0,  1,  24'h011000, 1'b0, 24'h011000, 1'b0};
        vt[4]  = '{8,  0,  24'h091000, 1'b0, 24'h091000, 1'b0};
        vt[5]  = '{1,  0,  24'h101000, 1'b0, 24'h101000, 1'b0};
        vt[6]  = '{0,  49, 24'h105900, 1'b0, 24'h105900, 1'b0};
        vt[7]  = '{0,  1,  24'h100000, 1'b0, 24'h100000, 1'b0};
        vt[8]  = '{13, 0,  24'h230000, 1'b0, 24'h110000, 1'b1};
        vt[9]  = '{1,  0,  24'h000000, 1'b0, 24'h120000, 1'b0};
        vt[10] = '{2,  3,  24'h020300, 1'b0, 24'h020300, 1'b0};

        rst_n = 1'b0; run = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
        #12;
        chk("reset_bcd", 32'(bcd), 32'd0);
        chk("reset_dig", 32'(dig), 32'h01);
        chk("reset_sec_tick", 32'(sec_tick), 32'd0);
        chk("reset_pm", 32'(pm), 32'd0);

        // Cumulative manual set table, time frozen.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            pulse_hr(vt[i].hr_n);
            pulse_min(vt[i].min_n);
            read_time(t, ok);
            chk($sformatf("vec%0d_read", i), 32'(ok), 32'd1);
            chk($sformatf("vec%0d_time", i), 32'(t), 32'(H12 ? vt[i].exp12 : vt[i].exp24));
            chk($sformatf("vec%0d_pm", i), 32'(pm), 32'(H12 ? vt[i].pm12 : vt[i].pm24));
        end

        // 240 cycles of running: 60 ticks, 4 cycles apart, ends at 00:01:00.
        do_reset();
        run_ticks(60, bad);
        chk("run60_intervals", 32'(bad), 32'd0);
        read_time(t, ok);
        chk("run60_time", 32'(t), H12 ? 32'h120100 : 32'h000100);

        // inc_min coincident with the seconds carry from :59.
        do_reset();
        run_ticks(59, bad);
        chk("carry_pre_intervals", 32'(bad), 32'd0);
        read_time(t, ok);
        chk("carry_pre_time", 32'(t), H12 ? 32'h120059 : 32'h000059);
        run = 1'b1;
        wait_tick(c);
        chk("carry_tick_seen", 32'(c), 32'(TICK));
        inc_min = 1'b1;
        @(negedge clk);
        inc_min = 1'b0; run = 1'b0;
        read_time(t, ok);
        chk("carry_inc_min_time", 32'(t), H12 ? 32'h120100 : 32'h000100);

        // Full rollover 23:59:59 (11:59:59 PM) -> 00:00:00 (12:00:00 AM).
        do_reset();
        pulse_hr(23);
        pulse_min(59);
        run_ticks(59, bad);
        read_time(t, ok);
        chk("roll_pre_time", 32'(t), H12 ? 32'h115959 : 32'h235959);
        chk("roll_pre_pm", 32'(pm), 32'(H12));
        run_ticks(1, bad);
        chk("roll_interval", 32'(bad), 32'd0);
        read_time(t, ok);
        chk("roll_time", 32'(t), H12 ? 32'h120000 : 32'h000000);
        chk("roll_pm", 32'(pm), 32'd0);

        // Scan order for 12:34:56.
        do_reset();
        pulse_hr(12);
        pulse_min(34);
        run_ticks(56, bad);
        repeat (2) @(negedge clk);
        exp_d[0] = 4'd6; exp_d[1] = 4'd5; exp_d[2] = 4'd4;
        exp_d[3] = 4'd3; exp_d[4] = 4'd2; exp_d[5] = 4'd1;
        hits = 0;
        prev = dig;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dig == 6'b000001 && prev == 6'b100000) begin
                hits = 1;
                break;
            end
            prev = dig;
        end
        chk("scan_sync_found", 32'(hits), 32'd1);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("scan_%0d", k), {22'd0, dig, bcd},
                {22'd0, 6'(6'b000001 << (k / 2)), exp_d[k / 2]});
            @(negedge clk);
        end

        // Asynchronous reset mid-count with run=0, then frozen time.
        do_reset();
        run = 1'b1;
        repeat (7) @(negedge clk);
        run = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_bcd", 32'(bcd), 32'd0);
        chk("async_rst_dig", 32'(dig), 32'h01);
        chk("async_rst_sec_tick", 32'(sec_tick), 32'd0);
        chk("async_rst_pm", 32'(pm), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sec_tick) hits++;
        end
        chk("frozen_no_tick", 32'(hits), 32'd0);
        read_time(t, ok);
        chk("frozen_time", 32'(t), H12 ? 32'h120000 : 32'h000000);

        // Reset mid-count with run=1: partial count discarded.
        run = 1'b1;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(c);
        chk("first_tick_after_reset", 32'(c >= TICK && c <= TICK + 3), 32'd1);
        run = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
